// File: rtl/config_sequencer.sv
// config_sequencer
//   Sequences runtime reconfiguration of the instrumentation pipeline.
//   When tracing is active it first holds the upstream stalled while
//   in-flight trace data drains, then drops tracing. For each unit in turn it
//   buffers BYTES_PER_UNIT firmware bytes from the host byte stream. It then
//   replays them as one gap-free configId/configData burst, because units
//   restart their byte counter on any non-matching configId. Finally it
//   restores tracing if the host still requests it.
//
// Ports
//   clk         clock
//   rst_n       asynchronous active-low reset
//   trace_en    host request: tracing on when not configuring
//   cfg_start   pulse: begin full reconfiguration (IDLE/TRACE only)
//   cfg_valid   host byte valid
//   cfg_byte    host firmware byte
//   cfg_ready   byte accepted when cfg_valid && cfg_ready (high only in FETCH)
//   input_stall upstream must not assert valid_in while high
//   tracing     shared tracing bus
//   configId    shared config id bus
//   configData  shared config data bus
//   cfg_busy    high from cfg_start acceptance until DONE
//   cfg_done    one-cycle pulse when the last unit has been loaded
module config_sequencer #(
    parameter int unsigned NUM_UNITS      = 4,
    parameter int unsigned MAX_CHAINS     = 4,
    parameter int unsigned BYTES_PER_UNIT = 3 * MAX_CHAINS,
    parameter int unsigned UNIT_ID_BASE   = 0,
    parameter logic [7:0]  IDLE_ID        = 8'hFF,
    parameter int unsigned DRAIN_CYCLES   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trace_en,
    input  logic       cfg_start,
    input  logic       cfg_valid,
    input  logic [7:0] cfg_byte,
    output logic       cfg_ready,
    output logic       input_stall,
    output logic       tracing,
    output logic [7:0] configId,
    output logic [7:0] configData,
    output logic       cfg_busy,
    output logic       cfg_done
);

    localparam int UW     = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam int DW     = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam int BW     = (BYTES_PER_UNIT > 1) ? $clog2(BYTES_PER_UNIT) : 1;
    localparam int BDEPTH = 1 << BW;

    localparam logic [7:0]    LAST_IDX   = 8'(BYTES_PER_UNIT - 1);
    localparam logic [UW-1:0] LAST_U     = UW'(NUM_UNITS - 1);
    localparam logic [DW-1:0] LAST_DRAIN = DW'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_TRACE = 3'd1,
        S_DRAIN = 3'd2,
        S_FETCH = 3'd3,
        S_EMIT  = 3'd4,
        S_GAP   = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t          state_r, state_s;
    logic [7:0]      idx_r, idx_s;
    logic [7:0]      k_r, k_s;
    logic [UW-1:0]   u_r, u_s;
    logic [DW-1:0]   dcnt_r, dcnt_s;
    logic            wr_s;
    logic [7:0]      data_buf_r [0:BDEPTH-1];

    logic            tracing_r, tracing_s;
    logic            stall_r, stall_s;
    logic            busy_r, busy_s;
    logic            done_r, done_s;
    logic [7:0]      id_r, id_s;
    logic [7:0]      data_r, data_s;

    // State and sequencing counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
            idx_r   <= 8'd0;
            k_r     <= 8'd0;
            u_r     <= '0;
            dcnt_r  <= '0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            k_r     <= k_s;
            u_r     <= u_s;
            dcnt_r  <= dcnt_s;
        end
    end

    // Firmware byte buffer; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (wr_s) begin
            data_buf_r[idx_r[BW-1:0]] <= cfg_byte;
        end
    end

    // Next-state and counter update logic.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        k_s     = k_r;
        u_s     = u_r;
        dcnt_s  = dcnt_r;
        wr_s    = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (cfg_start) begin
                    state_s = S_FETCH;
                    u_s     = '0;
                    idx_s   = 8'd0;
                end else if (trace_en) begin
                    state_s = S_TRACE;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_TRACE: begin
                // A start request outranks a simultaneous trace_en fall.
                if (cfg_start) begin
                    state_s = S_DRAIN;
                    dcnt_s  = '0;
                end else if (!trace_en) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_TRACE;
                end
            end
            S_DRAIN: begin
                if (dcnt_r == LAST_DRAIN) begin
                    state_s = S_FETCH;
                    u_s     = '0;
                    idx_s   = 8'd0;
                end else begin
                    dcnt_s = dcnt_r + DW'(1);
                end
            end
            S_FETCH: begin
                if (cfg_valid) begin
                    wr_s = 1'b1;
                    if (idx_r == LAST_IDX) begin
                        state_s = S_EMIT;
                        k_s     = 8'd0;
                    end else begin
                        idx_s = idx_r + 8'd1;
                    end
                end else begin
                    state_s = S_FETCH;
                end
            end
            S_EMIT: begin
                if (k_r == LAST_IDX) begin
                    state_s = S_GAP;
                end else begin
                    k_s = k_r + 8'd1;
                end
            end
            S_GAP: begin
                if (u_r == LAST_U) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_FETCH;
                    u_s     = u_r + UW'(1);
                    idx_s   = 8'd0;
                end
            end
            S_DONE: begin
                if (trace_en) begin
                    state_s = S_TRACE;
                end else begin
                    state_s = S_IDLE;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so the registered bus values line
    // up with the state they belong to.
    always_comb begin
        tracing_s = (state_s == S_TRACE) || (state_s == S_DRAIN);
        busy_s    = (state_s == S_DRAIN) || (state_s == S_FETCH) ||
                    (state_s == S_EMIT)  || (state_s == S_GAP)   ||
                    (state_s == S_DONE);
        // Stall persists through the load only when the load came via DRAIN.
        stall_s   = (state_s == S_DRAIN) ||
                    (stall_r && ((state_s == S_FETCH) || (state_s == S_EMIT) ||
                                 (state_s == S_GAP)   || (state_s == S_DONE)));
        done_s    = (state_s == S_DONE);
        if (state_s == S_EMIT) begin
            id_s = 8'(UNIT_ID_BASE) + 8'(u_s);
            // The byte being accepted this cycle is not in the buffer yet.
            if (wr_s && (idx_r[BW-1:0] == k_s[BW-1:0])) begin
                data_s = cfg_byte;
            end else begin
                data_s = data_buf_r[k_s[BW-1:0]];
            end
        end else begin
            id_s   = IDLE_ID;
            data_s = 8'h00;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tracing_r <= 1'b0;
            stall_r   <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            id_r      <= IDLE_ID;
            data_r    <= 8'h00;
        end else begin
            tracing_r <= tracing_s;
            stall_r   <= stall_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
            id_r      <= id_s;
            data_r    <= data_s;
        end
    end

    assign cfg_ready   = (state_r == S_FETCH);
    assign input_stall = stall_r;
    assign tracing     = tracing_r;
    assign configId    = id_r;
    assign configData  = data_r;
    assign cfg_busy    = busy_r;
    assign cfg_done    = done_r;

endmodule

// File: tb/tb_config_sequencer.sv
// Directed bench for config_sequencer. Host bytes are pushed to a scoreboard
// queue as they are accepted; a negedge monitor pops and compares every
// cycle in which configId names a unit, and checks burst length.
module tb_config_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       trace_en;
    logic       cfg_start;
    logic       cfg_valid;
    logic [7:0] cfg_byte;
    logic       cfg_ready;
    logic       input_stall;
    logic       tracing;
    logic [7:0] configId;
    logic [7:0] configData;
    logic       cfg_busy;
    logic       cfg_done;

    config_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .trace_en    (trace_en),
        .cfg_start   (cfg_start),
        .cfg_valid   (cfg_valid),
        .cfg_byte    (cfg_byte),
        .cfg_ready   (cfg_ready),
        .input_stall (input_stall),
        .tracing     (tracing),
        .configId    (configId),
        .configData  (configData),
        .cfg_busy    (cfg_busy),
        .cfg_done    (cfg_done)
    );

    always #5 clk = ~clk;

    int          n_total  = 0;
    int          n_pass   = 0;
    logic [15:0] exp_q[$];
    int          run_len  = 0;
    int          bursts   = 0;
    int          done_cnt = 0;
    bit          mon_en   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_tracing"}, 32'(tracing), 32'd0);
        chk({tag, "_id"},      32'(configId), 32'hFF);
        chk({tag, "_data"},    32'(configData), 32'd0);
        chk({tag, "_stall"},   32'(input_stall), 32'd0);
        chk({tag, "_busy"},    32'(cfg_busy), 32'd0);
        chk({tag, "_done"},    32'(cfg_done), 32'd0);
        chk({tag, "_ready"},   32'(cfg_ready), 32'd0);
    endtask

    // Offer one byte after a random idle gap and wait for its acceptance.
    task automatic send_byte(input logic [7:0] id, input logic [7:0] b);
        int g;
        int gap;
        gap = int'($urandom_range(0, 2));
        cfg_valid = 1'b0;
        repeat (gap) @(negedge clk);
        cfg_byte  = b;
        cfg_valid = 1'b1;
        g = 0;
        while (cfg_ready !== 1'b1 && g < 300) begin
            @(negedge clk);
            g++;
        end
        if (g >= 300) begin
            chk("ready_timeout", 32'(cfg_ready), 32'd1);
        end else begin
            exp_q.push_back({id, b});
            @(negedge clk);
        end
        cfg_valid = 1'b0;
    endtask

    task automatic load_unit(input int u, input int base);
        for (int b = 0; b < 12; b++) begin
            send_byte(8'(u), 8'(base + u * 12 + b + 1));
        end
    endtask

    task automatic wait_done();
        int g;
        g = 0;
        while (cfg_done !== 1'b1 && g < 200) begin
            @(negedge clk);
            g++;
        end
        chk("cfg_done_pulse", 32'(cfg_done), 32'd1);
    endtask

    // Scoreboard monitor for the configId/configData bus.
    always @(negedge clk) begin
        if (!rst_n) begin
            run_len = 0;
        end else if (mon_en) begin
            if (configId !== 8'hFF) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_emit", 32'(configId), 32'hFF);
                end else begin
                    logic [15:0] e;
                    e = exp_q.pop_front();
                    chk("emit_id", 32'(configId), 32'(e[15:8]));
                    chk("emit_data", 32'(configData), 32'(e[7:0]));
                end
                chk("tracing_in_emit", 32'(tracing), 32'd0);
                run_len++;
            end else begin
                if (run_len != 0) begin
                    chk("burst_len", 32'(run_len), 32'd12);
                    bursts++;
                end
                run_len = 0;
            end
            if (cfg_done === 1'b1) done_cnt++;
        end
    end

    initial begin
        rst_n     = 1'b0;
        trace_en  = 1'b1;
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        cfg_byte  = 8'h00;

        // Reset values with trace_en high, then tracing after release.
        repeat (2) @(negedge clk);
        chk_reset("rst");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_trace_on", 32'(tracing), 32'd1);
        chk("rst_ready", 32'(cfg_ready), 32'd0);
        chk("rst_id", 32'(configId), 32'hFF);

        // cfg_start from TRACE: drain window then fetch.
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        chk("drain_stall", 32'(input_stall), 32'd1);
        chk("drain_trace", 32'(tracing), 32'd1);
        chk("drain_busy", 32'(cfg_busy), 32'd1);
        repeat (3) @(negedge clk);
        chk("drain_last_trace", 32'(tracing), 32'd1);
        chk("drain_last_ready", 32'(cfg_ready), 32'd0);
        @(negedge clk);
        chk("fetch_trace_off", 32'(tracing), 32'd0);
        chk("fetch_ready", 32'(cfg_ready), 32'd1);
        chk("fetch_stall", 32'(input_stall), 32'd1);
        chk("fetch_id", 32'(configId), 32'hFF);

        // Full load of bytes 0x01..0x30 with random valid gaps.
        mon_en = 1'b1;
        for (int u = 0; u < 4; u++) load_unit(u, 0);
        wait_done();
        chk("done_busy", 32'(cfg_busy), 32'd1);
        chk("done_stall", 32'(input_stall), 32'd1);
        chk("done_trace", 32'(tracing), 32'd0);
        @(negedge clk);
        chk("post_done_trace", 32'(tracing), 32'd1);
        chk("post_done_busy", 32'(cfg_busy), 32'd0);
        chk("post_done_stall", 32'(input_stall), 32'd0);
        chk("post_done_pulse", 32'(cfg_done), 32'd0);
        chk("done_count_1", 32'(done_cnt), 32'd1);
        chk("bursts_1", 32'(bursts), 32'd4);
        chk("queue_empty_1", 32'(exp_q.size()), 32'd0);

        // cfg_start from IDLE skips DRAIN; a second start during EMIT is ignored.
        trace_en = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_trace", 32'(tracing), 32'd0);
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        chk("idle_start_ready", 32'(cfg_ready), 32'd1);
        chk("idle_start_stall", 32'(input_stall), 32'd0);
        chk("idle_start_busy", 32'(cfg_busy), 32'd1);
        load_unit(0, 8'h40);
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        chk("restart_ignored_id", 32'(configId), 32'd0);
        chk("restart_ignored_stall", 32'(input_stall), 32'd0);
        for (int u = 1; u < 4; u++) load_unit(u, 8'h40);
        wait_done();
        chk("idle_done_stall", 32'(input_stall), 32'd0);
        @(negedge clk);
        chk("idle_post_trace", 32'(tracing), 32'd0);
        chk("idle_post_busy", 32'(cfg_busy), 32'd0);
        chk("done_count_2", 32'(done_cnt), 32'd2);
        chk("bursts_2", 32'(bursts), 32'd8);

        // Reset during EMIT of unit 1, then a complete reload from unit 0.
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        load_unit(0, 8'h80);
        load_unit(1, 8'h80);
        repeat (2) @(negedge clk);
        chk("pre_rst_id", 32'(configId), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset("mid_rst");
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("after_rst_trace", 32'(tracing), 32'd0);
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        for (int u = 0; u < 4; u++) load_unit(u, 8'hA0);
        wait_done();
        @(negedge clk);
        chk("done_count_3", 32'(done_cnt), 32'd3);
        chk("bursts_3", 32'(bursts), 32'd13);
        chk("queue_empty_3", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
